bp_fe_instr_queue: RTL and testbench

Front-end instruction queue sitting directly downstream of the fetch realigner. It buffers fully assembled instructions, each with its PC and length, in a small circular FIFO, and presents them in order to the decode/issue boundary over a valid/yumi handshake. It supplies the `ready_then` credit that gates the realigner's output. A backend redirect flushes it in a single cycle.

---
 rtl/bp_fe_instr_queue.sv | 119 +++++++++++
 tb/tb_bp_fe_instr_queue.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_instr_queue.sv
// Front-end instruction queue: small circular FIFO of realigned instructions
// between the fetch realigner and decode/issue, with a single-cycle redirect flush.
module bp_fe_instr_queue
  #(parameter int e_bp_default_cfg = 0
   ,parameter int bp_params_p      = e_bp_default_cfg
   ,parameter int els_p            = 4
   ,localparam int vaddr_width_p   = (bp_params_p == e_bp_default_cfg) ? 39 : 64
   ,localparam int instr_width_gp  = 32
   ,localparam int ptr_w_lp        = (els_p > 1) ? $clog2(els_p) : 1
   ,localparam int cnt_w_lp        = $clog2(els_p + 1)
   )
  (input  logic                      clk_i
  ,input  logic                      reset_i

  ,input  logic                      fetch_instr_v_i
  ,input  logic [vaddr_width_p-1:0]  fetch_pc_i
  ,input  logic [instr_width_gp-1:0] fetch_instr_i
  ,input  logic                      fetch_partial_i
  ,output logic                      ready_then_o

  ,input  logic                      redirect_v_i

  ,output logic                      issue_v_o
  ,output logic [vaddr_width_p-1:0]  issue_pc_o
  ,output logic [instr_width_gp-1:0] issue_instr_o
  ,output logic                      issue_compressed_o
  ,output logic                      issue_partial_o
  ,input  logic                      issue_yumi_i

  ,output logic                      empty_o
  ,output logic [cnt_w_lp-1:0]       count_o
  );

  if ((els_p < 2) || ((els_p & (els_p - 1)) != 0)) begin : g_bad_depth
    $error("bp_fe_instr_queue: els_p must be a power of two and at least 2");
  end

  typedef struct packed {
    logic [vaddr_width_p-1:0]  pc;
    logic [instr_width_gp-1:0] instr;
    logic                      compressed;
    logic                      partial;
  } entry_t;

  entry_t                mem_q [els_p];
  entry_t                entry_d;
  entry_t                head;

  logic [ptr_w_lp-1:0]   wptr_q, wptr_d;
  logic [ptr_w_lp-1:0]   rptr_q, rptr_d;
  logic [cnt_w_lp-1:0]   count_q, count_d;
  logic                  enq, deq;

  // Credit and head status come from registered state only, so the producer
  // and consumer may depend on them combinationally without forming loops.
  assign ready_then_o = (count_q != cnt_w_lp'(els_p));
  assign issue_v_o    = (count_q != '0);
  assign empty_o      = (count_q == '0);
  assign count_o      = count_q;

  always_comb begin
    entry_d            = '0;
    entry_d.pc         = fetch_pc_i;
    entry_d.partial    = fetch_partial_i;
    entry_d.compressed = (fetch_instr_i[1:0] != 2'b11);
    entry_d.instr      = entry_d.compressed
                         ? {16'b0, fetch_instr_i[15:0]}
                         : fetch_instr_i;
  end

  // A full queue refuses enqueue even when a dequeue frees a slot this cycle.
  always_comb begin
    enq     = fetch_instr_v_i & ready_then_o & ~redirect_v_i;
    deq     = issue_yumi_i & issue_v_o & ~redirect_v_i;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (redirect_v_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (enq) wptr_d = wptr_q + ptr_w_lp'(1);
      if (deq) rptr_d = rptr_q + ptr_w_lp'(1);
      count_d = count_q + cnt_w_lp'(enq) - cnt_w_lp'(deq);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage carries no reset; it is only meaningful while counted.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr_q] <= entry_d;
  end

  assign head               = mem_q[rptr_q];
  assign issue_pc_o         = head.pc;
  assign issue_instr_o      = head.instr;
  assign issue_compressed_o = head.compressed;
  assign issue_partial_o    = head.partial;

  a_yumi_without_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    !(issue_yumi_i && !issue_v_o));
  a_enq_without_credit: assert property (@(posedge clk_i) disable iff (reset_i)
    !(fetch_instr_v_i && !ready_then_o));
  a_count_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
    (count_q <= cnt_w_lp'(els_p)));

endmodule

// File: tb/tb_bp_fe_instr_queue.sv
// Scoreboard bench for bp_fe_instr_queue: randomized and directed traffic checked
// against a queue-based model of the FIFO rules.
module tb_bp_fe_instr_queue;
  localparam int VW  = 39;
  localparam int ELS = 4;

  typedef struct {
    logic [VW-1:0] pc;
    logic [31:0]   instr;
    logic          c;
    logic          p;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          fetch_instr_v_i = 1'b0;
  logic [VW-1:0] fetch_pc_i = '0;
  logic [31:0]   fetch_instr_i = '0;
  logic          fetch_partial_i = 1'b0;
  logic          ready_then_o;
  logic          redirect_v_i = 1'b0;
  logic          issue_v_o;
  logic [VW-1:0] issue_pc_o;
  logic [31:0]   issue_instr_o;
  logic          issue_compressed_o;
  logic          issue_partial_o;
  logic          issue_yumi_i = 1'b0;
  logic          empty_o;
  logic [2:0]    count_o;

  int errors = 0;
  int checks = 0;
  exp_t exp_q[$];

  bp_fe_instr_queue #(.els_p(ELS)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .fetch_instr_v_i(fetch_instr_v_i), .fetch_pc_i(fetch_pc_i),
    .fetch_instr_i(fetch_instr_i), .fetch_partial_i(fetch_partial_i),
    .ready_then_o(ready_then_o), .redirect_v_i(redirect_v_i),
    .issue_v_o(issue_v_o), .issue_pc_o(issue_pc_o), .issue_instr_o(issue_instr_o),
    .issue_compressed_o(issue_compressed_o), .issue_partial_o(issue_partial_o),
    .issue_yumi_i(issue_yumi_i), .empty_o(empty_o), .count_o(count_o));

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; requests are gated so the handshake stays legal.
  task automatic step(input logic v, input logic [VW-1:0] pc, input logic [31:0] ins,
                      input logic part, input logic y, input logic rd);
    fetch_instr_v_i = v & ready_then_o;
    fetch_pc_i      = pc;
    fetch_instr_i   = ins;
    fetch_partial_i = part;
    issue_yumi_i    = y & issue_v_o;
    redirect_v_i    = rd;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    fetch_instr_v_i = 1'b0;
    issue_yumi_i    = 1'b0;
    redirect_v_i    = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 2 * ELS && issue_v_o; k++) step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    idle();
  endtask

  // Monitor: model occupancy from the queue rules, compare status every cycle
  // and compare head fields whenever the consumer takes an entry.
  initial begin : monitor
    exp_t hd, ne;
    bit   do_enq;
    forever begin
      @(negedge clk_i or posedge reset_i);
      if (reset_i) begin
        exp_q.delete();
        continue;
      end
      chk("count", 64'(count_o), 64'(exp_q.size()));
      chk("issue_v", 64'(issue_v_o), 64'(exp_q.size() != 0));
      chk("ready_then", 64'(ready_then_o), 64'(exp_q.size() != ELS));
      chk("empty", 64'(empty_o), 64'(exp_q.size() == 0));
      if (redirect_v_i) begin
        exp_q.delete();
        continue;
      end
      do_enq = fetch_instr_v_i && (exp_q.size() < ELS);
      if (issue_yumi_i && exp_q.size() > 0) begin
        hd = exp_q.pop_front();
        chk("issue_pc", 64'(issue_pc_o), 64'(hd.pc));
        chk("issue_instr", 64'(issue_instr_o), 64'(hd.instr));
        chk("issue_compressed", 64'(issue_compressed_o), 64'(hd.c));
        chk("issue_partial", 64'(issue_partial_o), 64'(hd.p));
      end
      if (do_enq) begin
        ne.pc    = fetch_pc_i;
        ne.c     = (fetch_instr_i[1:0] != 2'b11);
        ne.instr = ne.c ? (fetch_instr_i & 32'h0000_FFFF) : fetch_instr_i;
        ne.p     = fetch_partial_i;
        exp_q.push_back(ne);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [VW-1:0] pc;
    int sent;
    repeat (3) @(posedge clk_i);
    #1 reset_i = 1'b0;
    #1;
    chk("reset_issue_v", 64'(issue_v_o), 64'd0);
    chk("reset_empty", 64'(empty_o), 64'd1);
    chk("reset_count", 64'(count_o), 64'd0);
    chk("reset_ready", 64'(ready_then_o), 64'd1);
    @(posedge clk_i); #1;

    // Basic order, including compressed upper-half zeroing
    step(1'b1, 39'h0_8000_0000, 32'h0000_0013, 1'b0, 1'b0, 1'b0);
    chk("basic_first_pc", 64'(issue_pc_o), 64'h8000_0000);
    step(1'b1, 39'h0_8000_0004, 32'hFFFF_0001, 1'b0, 1'b1, 1'b0);
    chk("basic_second_pc", 64'(issue_pc_o), 64'h8000_0004);
    chk("basic_second_instr", 64'(issue_instr_o), 64'h0000_0001);
    chk("basic_second_c", 64'(issue_compressed_o), 64'd1);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    idle();
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Fill to capacity, then one dequeue reopens credit
    pc = 39'h0_8000_1000;
    for (int i = 0; i < ELS; i++) begin
      step(1'b1, pc, 32'h0000_0033 | (i << 7), 1'b0, 1'b0, 1'b0);
      pc += 4;
    end
    chk("fill_count", 64'(count_o), 64'd4);
    chk("fill_ready", 64'(ready_then_o), 64'd0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    chk("fill_deq_count", 64'(count_o), 64'd3);
    chk("fill_deq_ready", 64'(ready_then_o), 64'd1);
    drain();

    // Simultaneous enq/deq at count 2, then full with dequeue only
    step(1'b1, pc, 32'h0000_4501, 1'b1, 1'b0, 1'b0); pc += 4;
    step(1'b1, pc, 32'h0000_0093, 1'b0, 1'b0, 1'b0); pc += 4;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, pc, $urandom, 1'($urandom), 1'b1, 1'b0);
      pc += 4;
    end
    chk("simul_count", 64'(count_o), 64'd2);
    step(1'b1, pc, $urandom, 1'b0, 1'b0, 1'b0); pc += 4;
    step(1'b1, pc, $urandom, 1'b0, 1'b0, 1'b0); pc += 4;
    chk("simul_full", 64'(count_o), 64'd4);
    step(1'b1, pc, $urandom, 1'b0, 1'b1, 1'b0); pc += 4;
    chk("simul_full_deq", 64'(count_o), 64'd3);
    drain();

    // Wrap-around stream with random consumer stalls
    sent = 0;
    for (int cyc = 0; cyc < 200 && sent < 20; cyc++) begin
      if (ready_then_o) sent++;
      step(1'b1, pc, $urandom, 1'($urandom), 1'($urandom), 1'b0);
      if (ready_then_o || sent < 20) pc += (fetch_instr_v_i ? 4 : 0);
    end
    chk("wrap_sent", 64'(sent), 64'd20);
    idle();
    drain();

    // Redirect at count 3 together with an enqueue
    for (int i = 0; i < 3; i++) begin
      step(1'b1, pc, $urandom, 1'b0, 1'b0, 1'b0);
      pc += 4;
    end
    step(1'b1, pc, 32'h0000_0013, 1'b0, 1'b1, 1'b1);
    chk("redirect_count", 64'(count_o), 64'd0);
    chk("redirect_issue_v", 64'(issue_v_o), 64'd0);
    step(1'b1, 39'h0_9000_0000, 32'h0000_0513, 1'b0, 1'b0, 1'b0);
    chk("redirect_new_v", 64'(issue_v_o), 64'd1);
    chk("redirect_new_pc", 64'(issue_pc_o), 64'h9000_0000);
    drain();

    // Asynchronous reset mid-stream
    step(1'b1, pc, 32'h0000_8082, 1'b1, 1'b0, 1'b0); pc += 4;
    step(1'b1, pc, 32'h0000_8082, 1'b1, 1'b0, 1'b0); pc += 4;
    idle();
    #1 reset_i = 1'b1;
    #1;
    chk("areset_issue_v", 64'(issue_v_o), 64'd0);
    chk("areset_count", 64'(count_o), 64'd0);
    #1 reset_i = 1'b0;
    #1;
    chk("areset_release_count", 64'(count_o), 64'd0);
    chk("areset_release_ready", 64'(ready_then_o), 64'd1);
    @(posedge clk_i); #1;
    step(1'b1, 39'h0_A000_0000, 32'h0000_4505, 1'b0, 1'b0, 1'b0);
    chk("areset_partial", 64'(issue_partial_o), 64'd0);
    chk("areset_pc", 64'(issue_pc_o), 64'hA000_0000);
    drain();
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
